// File: rtl/exp_pkg.sv
// Shared types and Q8.8 constants for the exponential-series sequencer.
package exp_pkg;

  // Sequencer states, one cycle each except IDLE
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    MUL_X,
    MUL_R,
    ACC,
    DONE
  } state_t;

  // 1.0 in Q8.8 and the number of fractional bits dropped after a multiply
  localparam logic [15:0] ONE_Q88   = 16'd256;
  localparam int          FRAC_BITS = 8;

  // Depth of the external reciprocal ROM; bounds the number of series terms
  localparam int          LUT_DEPTH = 12;

endpackage

// File: rtl/exp_series_ctrl_if.sv
// Host-side start/done handshake of the exponential-series sequencer.
// The host drives start/x_in and watches busy/done/result.
interface exp_series_ctrl_if #(
  parameter int DW = 16
);

  logic          start;
  logic [7:0]    x_in;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;

  modport master (
    output start,
    output x_in,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  x_in,
    output busy,
    output done,
    output result
  );

endinterface

// File: rtl/qmul_q88.sv
// Shared Q8.8 multiplier: full-width product of two DW operands,
// truncated back to DW bits by dropping the fractional LSBs.
module qmul_q88
  import exp_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  logic [2*DW-1:0] prod;

  // Combinational multiply; the upper integer bits beyond DW are discarded
  // because the operands never exceed 1.0 in practice.
  always_comb begin
    prod = (2*DW)'(a) * (2*DW)'(b);
    y    = DW'(prod >> FRAC_BITS);
  end

endmodule

// File: rtl/exp_series_ctrl.sv
// Truncated Taylor-series sequencer for e^x with x in Q0.8.
// Each term is built from the previous one in two multiplies on one shared
// multiplier (times x, then times 1/(i+1) from the external ROM) and then
// accumulated. Three cycles per term plus one INIT and one DONE cycle.
module exp_series_ctrl
  import exp_pkg::*;
#(
  parameter int N_TERMS = 12,
  parameter int DW      = 16,
  parameter int AW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  exp_series_ctrl_if.slave     bus,
  output logic [AW-1:0]        lut_addr,
  input  logic [DW-1:0]        lut_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_TERMS - 1);

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    x_q;
  logic [DW-1:0] term_q;
  logic [DW-1:0] sum_q;
  logic [DW-1:0] result_q;
  logic [AW-1:0] iter_q;

  logic [DW-1:0] mul_b;
  logic [DW-1:0] mul_y;
  logic [DW:0]   sum_ext;
  logic          last_iter;
  logic          busy_c;
  logic          done_c;

  assign last_iter  = (iter_q == LAST_IDX);
  assign lut_addr   = iter_q;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the busy/done status decoded from the state
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = INIT;
        end
      end
      INIT: begin
        busy_c    = 1'b1;
        state_nxt = MUL_X;
      end
      MUL_X: begin
        busy_c    = 1'b1;
        state_nxt = MUL_R;
      end
      MUL_R: begin
        busy_c    = 1'b1;
        state_nxt = ACC;
      end
      ACC: begin
        busy_c    = 1'b1;
        state_nxt = last_iter ? DONE : MUL_X;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Second multiplier operand: zero-extended x in MUL_X, ROM reciprocal otherwise
  always_comb begin
    mul_b = lut_data;
    if (state == MUL_X) begin
      mul_b = {{(DW-8){1'b0}}, x_q};
    end
  end

  qmul_q88 #(
    .DW (DW)
  ) u_qmul (
    .a (term_q),
    .b (mul_b),
    .y (mul_y)
  );

  // Running sum with one guard bit so an overflow can be detected
  always_comb begin
    sum_ext = {1'b0, sum_q} + {1'b0, term_q};
  end

  // Datapath registers: operand capture, term/sum update, counter, result
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      term_q   <= '0;
      sum_q    <= '0;
      iter_q   <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q <= bus.x_in;
          end
        end
        INIT: begin
          term_q <= DW'(ONE_Q88);
          sum_q  <= DW'(ONE_Q88);
          iter_q <= '0;
        end
        MUL_X: begin
          term_q <= mul_y;
        end
        MUL_R: begin
          term_q <= mul_y;
        end
        ACC: begin
          sum_q <= sum_ext[DW-1:0];
          if (last_iter) begin
            result_q <= sum_ext[DW-1:0];
          end else begin
            iter_q <= iter_q + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sanity guards: the sum must never carry out and the ROM is never over-read
  always_ff @(posedge clk) begin
    if (!rst && state == ACC) begin
      assert (sum_ext[DW] == 1'b0);
      assert (int'(iter_q) < LUT_DEPTH);
    end
  end

endmodule

// File: tb/tb_exp_series_ctrl.sv
// Directed self-checking bench for exp_series_ctrl with a result scoreboard.
// Two instances share the clock and reset: one with 12 terms, one with 2.
module tb_exp_series_ctrl;

  logic clk = 1'b0;
  logic rst;

  exp_series_ctrl_if #(.DW(16)) busA ();
  exp_series_ctrl_if #(.DW(16)) busB ();

  logic [3:0]  lutAddrA;
  logic [3:0]  lutAddrB;
  logic [15:0] lutDataA;
  logic [15:0] lutDataB;

  int errors  = 0;
  int checks  = 0;
  int cycleNo = 0;
  int tFirst;
  int tSecond;
  bit quiet;

  logic [15:0] sbQueue[$];

  exp_series_ctrl #(
    .N_TERMS (12),
    .DW      (16),
    .AW      (4)
  ) dutA (
    .clk      (clk),
    .rst      (rst),
    .bus      (busA),
    .lut_addr (lutAddrA),
    .lut_data (lutDataA)
  );

  exp_series_ctrl #(
    .N_TERMS (2),
    .DW      (16),
    .AW      (4)
  ) dutB (
    .clk      (clk),
    .rst      (rst),
    .bus      (busB),
    .lut_addr (lutAddrB),
    .lut_data (lutDataB)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure done spacing
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Reciprocal ROM contents, Q8.8 of 1/(i+1); entry 0 holds 0x00FF
  function automatic logic [15:0] romVal(input logic [3:0] a);
    case (a)
      4'd0:    romVal = 16'd255;
      4'd1:    romVal = 16'd128;
      4'd2:    romVal = 16'd85;
      4'd3:    romVal = 16'd64;
      4'd4:    romVal = 16'd51;
      4'd5:    romVal = 16'd42;
      4'd6:    romVal = 16'd36;
      4'd7:    romVal = 16'd32;
      4'd8:    romVal = 16'd28;
      4'd9:    romVal = 16'd25;
      4'd10:   romVal = 16'd23;
      4'd11:   romVal = 16'd21;
      default: romVal = 16'd0;
    endcase
  endfunction

  // Combinational ROM models
  always_comb lutDataA = romVal(lutAddrA);
  always_comb lutDataB = romVal(lutAddrB);

  // Reference series: term = trunc(term*x), term = trunc(term*recip), sum += term
  function automatic logic [15:0] seriesModel(input logic [7:0] x, input int n);
    logic [31:0] p;
    logic [15:0] t;
    logic [15:0] s;
    t = 16'd256;
    s = 16'd256;
    for (int k = 0; k < n; k++) begin
      p = 32'(t) * 32'(x);
      t = p[23:8];
      p = 32'(t) * 32'(romVal(4'(k)));
      t = p[23:8];
      s = s + t;
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, queue the expected result, end in cycle 1
  task automatic applyStimulus(input bit useB, input logic [7:0] x, input int n);
    @(negedge clk);
    if (useB) begin
      busB.start = 1'b1;
      busB.x_in  = x;
    end else begin
      busA.start = 1'b1;
      busA.x_in  = x;
    end
    sbQueue.push_back(seriesModel(x, n));
    @(negedge clk);
    busA.start = 1'b0;
    busB.start = 1'b0;
    checkOutput("busyRise", useB ? busB.busy : busA.busy, 1);
  endtask

  // Wait (bounded) for done, checking timing, address sweep and scoreboard
  task automatic waitDone(input bit useB, input int nTerms, input int c0, output int doneAbs);
    int          c;
    bit          seen;
    bit          addrOk;
    logic [3:0]  addr;
    logic [15:0] res;
    logic [15:0] expRes;
    logic        bsy;
    c       = c0;
    seen    = 1'b0;
    addrOk  = 1'b1;
    doneAbs = 0;
    while (!seen && c < c0 + 200) begin
      @(negedge clk);
      c++;
      addr = useB ? lutAddrB : lutAddrA;
      if (c >= 2 && c <= 3 * nTerms + 1 && addr !== 4'((c - 2) / 3)) addrOk = 1'b0;
      seen = useB ? busB.done : busA.done;
    end
    checkOutput("doneSeen", 32'(seen), 1);
    if (seen) begin
      res = useB ? busB.result : busA.result;
      bsy = useB ? busB.busy : busA.busy;
      checkOutput("doneCycle", c, 3 * nTerms + 2);
      checkOutput("lutSweep", 32'(addrOk), 1);
      checkOutput("busyAtDone", bsy, 0);
      checkOutput("sbNotEmpty", 32'(sbQueue.size() != 0), 1);
      if (sbQueue.size() != 0) begin
        expRes = sbQueue.pop_front();
        checkOutput("sbResult", res, expRes);
      end
      doneAbs = cycleNo;
    end
  endtask

  initial begin
    rst        = 1'b1;
    busA.start = 1'b0;
    busA.x_in  = 8'd0;
    busB.start = 1'b0;
    busB.x_in  = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", busA.busy, 0);
    checkOutput("rstDone", busA.done, 0);
    checkOutput("rstResult", busA.result, 0);
    checkOutput("rstLutAddr", lutAddrA, 0);
    checkOutput("rstResultB", busB.result, 0);
    rst = 1'b0;

    // x = 0 gives exactly 1.0, single-cycle done pulse
    applyStimulus(1'b0, 8'd0, 12);
    waitDone(1'b0, 12, 1, tFirst);
    checkOutput("x0Result", busA.result, 16'h0100);
    @(negedge clk);
    checkOutput("donePulseOnce", busA.done, 0);

    // x = 0.5 with 12 terms
    applyStimulus(1'b0, 8'd128, 12);
    waitDone(1'b0, 12, 1, tFirst);
    checkOutput("x128Result", busA.result, 16'h01A2);

    // x = 0.5 with 2 terms, done in cycle 8
    applyStimulus(1'b1, 8'd128, 2);
    waitDone(1'b1, 2, 1, tFirst);
    checkOutput("x128N2Result", busB.result, 16'h019E);

    // Start pulses while busy and during DONE are ignored
    applyStimulus(1'b0, 8'd128, 12);
    repeat (3) @(negedge clk);
    busA.start = 1'b1;
    busA.x_in  = 8'd255;
    @(negedge clk);
    busA.start = 1'b0;
    waitDone(1'b0, 12, 5, tFirst);
    busA.start = 1'b1;
    busA.x_in  = 8'd255;
    @(negedge clk);
    busA.start = 1'b0;
    checkOutput("ignoreDoneStartBusy", busA.busy, 0);
    checkOutput("ignoreDoneStartDone", busA.done, 0);
    quiet = 1'b1;
    repeat (45) begin
      @(negedge clk);
      if (busA.done !== 1'b0 || busA.busy !== 1'b0) quiet = 1'b0;
    end
    checkOutput("ignoreNoSecondRun", 32'(quiet), 1);
    checkOutput("ignoreResult", busA.result, 16'h01A2);

    // Reset in cycle 10 of a run aborts it silently
    applyStimulus(1'b0, 8'd128, 12);
    repeat (9) @(negedge clk);
    checkOutput("midRunLutAddr", lutAddrA, 2);
    checkOutput("midRunBusy", busA.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", busA.busy, 0);
    checkOutput("abortResult", busA.result, 0);
    checkOutput("abortLutAddr", lutAddrA, 0);
    checkOutput("abortDone", busA.done, 0);
    rst = 1'b0;
    sbQueue.delete();
    applyStimulus(1'b0, 8'd0, 12);
    waitDone(1'b0, 12, 1, tFirst);
    checkOutput("afterAbortResult", busA.result, 16'h0100);

    // Back-to-back runs: start in the IDLE cycle right after DONE
    @(negedge clk);
    applyStimulus(1'b0, 8'd128, 12);
    waitDone(1'b0, 12, 1, tFirst);
    checkOutput("b2bFirstResult", busA.result, 16'h01A2);
    applyStimulus(1'b0, 8'd0, 12);
    waitDone(1'b0, 12, 1, tSecond);
    checkOutput("b2bSecondResult", busA.result, 16'h0100);
    checkOutput("b2bSpacing", tSecond - tFirst, 39);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_series_ctrl.md
Name: exp_series_ctrl

Overview:
- Sequencer for the 12-entry reciprocal ROM (Q8.8 values of 1/(i+1), i = 0..11) and one shared 16x16 multiplier.
- Computes e^x as a truncated Taylor series. The update rule is term(i+1) = term(i) * x * (1/(i+1)) and sum += term.
- Sits between the accelerator's host-side start/done handshake and the combinational reciprocal ROM.
- Owns the iteration counter, the term and sum registers, and the FSM.

Parameters:
- N_TERMS, 12: number of series terms after the constant 1.0. Legal range 1..12, bounded by ROM depth.
- DW, 16: width of the datapath, ROM data and result (Q8.8).
- AW, 4: width of the ROM address.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a computation. Sampled only in IDLE.
- x_in, input, 8: operand x in Q0.8 (0 to 255/256). Captured on the accepted start.
- busy, output, 1: high from INIT through ACC inclusive.
- done, output, 1: one-cycle pulse, high in the DONE state.
- result, output, DW: e^x in Q8.8. Held from DONE until the next accepted start.
- lut_addr, output, AW: ROM address, always equal to iteration counter i.
- lut_data, input, DW: ROM read data (combinational, same cycle).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: FSM = IDLE; busy = 0; done = 0; result = 0; lut_addr = 0; x, term and sum registers = 0.
- Reset mid-operation: on the next edge, return to IDLE and clear everything. No done pulse is emitted.
- IDLE:
  - start = 1 latches x_in and moves to INIT.
  - start while busy or in DONE is ignored; no queueing.
- INIT (1 cycle): term = 256 (1.0), sum = 256, i = 0, then MUL_X.
- MUL_X (1 cycle): prod = term * {8'b0, x}. term = prod[23:8] (truncate). Go to MUL_R.
- MUL_R (1 cycle): prod = term * lut_data with lut_addr = i. term = prod[23:8] (truncate). Go to ACC.
- ACC (1 cycle): sum = sum + term (DW bits).
  - If i == N_TERMS-1, go to DONE.
  - Otherwise i = i+1 and go to MUL_X.
- DONE (1 cycle): done = 1, result = sum, busy = 0, then IDLE.
  - A start asserted during DONE is ignored.
  - A start asserted in the following IDLE cycle is accepted.
- Multiplier: exactly one 16x16 to 32 instance, muxed between the MUL_X and MUL_R operands. Only bits [23:8] are used.
- Range and saturation:
  - Since x < 1, term never exceeds 256 and sum stays below 700, so no overflow is possible.
  - An assertion must flag sum > 16'hFFFF; there is no saturation logic.
- Latency:
  - Call the cycle in which start is sampled in IDLE cycle 0.
  - done = 1 in cycle 3*N_TERMS + 2 (cycle 38 for N_TERMS = 12).
  - Throughput is one result per 3*N_TERMS + 3 cycles.
- lut_addr is registered (it is counter i), so the ROM has a full cycle to settle before MUL_R.
- result changes only on entry to DONE or on rst.

Decomposition:
- Shared package exp_pkg:
  - state enum {IDLE, INIT, MUL_X, MUL_R, ACC, DONE};
  - Q8.8 constants ONE_Q88 = 16'd256 and FRAC_BITS = 8;
  - LUT_DEPTH = 12.
- One natural sub-module, qmul_q88: the shared combinational multiply-and-shift (two DW inputs, DW output = product[23:8]).
- The reciprocal ROM stays external and is instantiated by the parent alongside this block.

Test Plan:
- x_in = 0, start for 1 cycle: busy rises in cycle 1, done pulses in cycle 38 only, result = 256 (16'h0100).
- x_in = 128 (0.5), N_TERMS = 12:
  - per-term sums are 383, 414, 418, 418, ... (terms 127, 31, 4, 0, ...);
  - result = 418 (16'h01A2) at cycle 38.
- x_in = 128, N_TERMS = 2: result = 414 (16'h019E), with done in cycle 8.
- Start pulses with x_in = 255 during busy and during DONE: ignored. Result reflects the first x_in = 128 (418), and no second done appears until a new start in IDLE.
- rst asserted in cycle 10 of a run: next cycle has busy = 0, result = 0, lut_addr = 0, and no done. A new start with x_in = 0 gives result = 256 at +38 cycles.
- Back-to-back runs (start in the IDLE cycle right after DONE, x = 128 then x = 0):
  - results 418 then 256;
  - done pulses are 39 cycles apart;
  - lut_addr sweeps 0..11 in each run.
